shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
Command-driven controller for the team's 8-bit load/shift-right register (LoadVal, Load_n, ShiftRight, ASR, clk, reset_n, Q).
- Accepts a command {data, shift amount, arithmetic flag} on a valid/ready handshake.
- Loads the shifter, then pulses ShiftRight the requested number of cycles.
- Returns the shifter output on a result valid/ready handshake.
- Sits between a requester (e.g. button/switch front-end or ALU sequencer) and one shifter instance; the shifter itself is external.

Parameters:
WIDTH, 8, shifter data width
AMT_W, 4, width of shift-amount field; must hold WIDTH

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
clear  input  1  synchronous abort; returns to IDLE, resets shifter
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
cmd_data  input  WIDTH  value to load
cmd_amt  input  AMT_W  number of right shifts, 0..WIDTH (larger saturates to WIDTH)
cmd_asr  input  1  1 = arithmetic (sign-fill), 0 = logical (zero-fill)
res_valid  output  1  result available
res_ready  input  1  requester takes result
res_data  output  WIDTH  shift result
busy  output  1  high in any state other than IDLE
sh_load_val  output  WIDTH  to shifter LoadVal
sh_load_n  output  1  to shifter Load_n (0 = load)
sh_shift  output  1  to shifter ShiftRight
sh_asr  output  1  to shifter ASR
sh_reset_n  output  1  to shifter reset_n (synchronous active-low in shifter)
sh_q  input  WIDTH  from shifter Q

Behaviour:
- Reset (reset_n=0, async): state=IDLE, cnt=0, latched amt/asr/data=0.
- Outputs during reset: cmd_ready=0, res_valid=0, busy=0, sh_load_n=1, sh_shift=0, sh_asr=0, sh_load_val=0.
- sh_reset_n=0 combinationally while reset_n=0.
- cmd_ready=1 only in IDLE, and only when reset_n=1 and clear=0.
- FSM states: IDLE, LOAD, SHIFT, RESP.
- IDLE: on cmd_valid&&cmd_ready, latch data, asr, and amt_sat=min(cmd_amt, WIDTH); go to LOAD.
- LOAD (1 cycle): sh_load_n=0, sh_load_val=latched data, sh_shift=0. Shifter captures at the end of this cycle.
  - If amt_sat=0, go to RESP; else cnt<=amt_sat, go to SHIFT.
- SHIFT: sh_load_n=1, sh_shift=1, sh_asr=latched asr. Each cycle cnt<=cnt-1; when cnt==1, go to RESP.
  - Exactly amt_sat shift cycles are issued.
- RESP: sh_load_n=1, sh_shift=0 (shifter holds). res_valid=1, res_data=sh_q.
  - Stay until res_ready=1; then go to IDLE.
  - res_data stable while res_valid && !res_ready.
- Outside RESP, res_data=0.
- Latency: command accepted at edge N; res_valid high from cycle N+2+amt_sat.
- No new command is accepted in the RESP cycle; the earliest next accept is the cycle after the result handshake.
- clear=1 (any state): next state IDLE, cnt=0. sh_reset_n=0 during that cycle (combinational). sh_load_n=1, sh_shift=0.
  - clear has priority over cmd_valid and res_ready; an in-flight result is discarded.
- sh_reset_n=1 at all other times.
- sh_asr=0 in all states except SHIFT.
- Result equivalence: logical = data>>amt_sat; arithmetic = signed(data)>>>amt_sat.
  - amt_sat=WIDTH gives 0 (logical) or all-sign-bits (arithmetic).
- Async reset mid-operation: immediate IDLE, no result emitted; shifter also reset via sh_reset_n.
- cmd_* inputs are sampled only at the accept edge; changes afterward are ignored.

Test Plan:
- Reset, then cmd data=8'hB4, amt=2, asr=0 -> sh_load_n low 1 cycle; sh_shift high exactly 2 cycles; res_valid at accept+4; res_data=8'h2D.
- cmd data=8'hB4, amt=3, asr=1 -> sh_asr=1 during all 3 SHIFT cycles, 0 elsewhere; res_data=8'hF6.
- Boundary amounts:
  - data=8'h81, amt=0 -> no shift cycles; res_valid at accept+2; res_data=8'h81.
  - data=8'h81, amt=15, asr=1 -> saturates to 8 shifts; res_data=8'hFF.
  - data=8'h81, amt=8, asr=0 -> res_data=8'h00.
- Backpressure: hold res_ready=0 for 5 cycles in RESP -> res_valid and res_data constant, cmd_ready=0 throughout; res_ready=1 -> IDLE next cycle, cmd_ready=1.
- clear asserted in the 2nd SHIFT cycle of an amt=5 op, cmd_valid also high -> sh_reset_n=0 for that cycle; next cycle IDLE; command not accepted; no res_valid.
- reset_n deasserted mid-SHIFT asynchronously -> outputs at reset values immediately; after release, a fresh cmd (8'h40, amt=1, asr=0) completes with res_data=8'h20.

Source files
------------

// File: rtl/shift_sequencer.sv
// Command-driven controller for an external 8-bit load/shift-right register:
// loads the shifter, issues the requested number of shift pulses, returns Q.
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [AMT_W-1:0] cmd_amt,
    input  logic             cmd_asr,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             busy,
    output logic [WIDTH-1:0] sh_load_val,
    output logic             sh_load_n,
    output logic             sh_shift,
    output logic             sh_asr,
    output logic             sh_reset_n,
    input  logic [WIDTH-1:0] sh_q
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, RESP} state_e;

    localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);

    state_e           state_q, state_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [AMT_W-1:0] amt_q, amt_d;
    logic             asr_q, asr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [AMT_W-1:0] amt_sat;

    assign amt_sat = (cmd_amt > AMT_MAX) ? AMT_MAX : cmd_amt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            amt_q   <= '0;
            asr_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            amt_q   <= amt_d;
            asr_q   <= asr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        amt_d       = amt_q;
        asr_d       = asr_q;
        data_d      = data_q;
        cmd_ready   = 1'b0;
        res_valid   = 1'b0;
        res_data    = '0;
        busy        = (state_q != IDLE);
        sh_load_val = '0;
        sh_load_n   = 1'b1;
        sh_shift    = 1'b0;
        sh_asr      = 1'b0;
        sh_reset_n  = reset_n && !clear;

        // clear wins over everything, including an unaccepted result
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cmd_ready = reset_n;
                    if (cmd_valid && reset_n) begin
                        data_d  = cmd_data;
                        asr_d   = cmd_asr;
                        amt_d   = amt_sat;
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    sh_load_n   = 1'b0;
                    sh_load_val = data_q;
                    if (amt_q == '0) begin
                        state_d = RESP;
                    end else begin
                        cnt_d   = amt_q;
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    sh_shift = 1'b1;
                    sh_asr   = asr_q;
                    cnt_d    = cnt_q - 1'b1;
                    if (cnt_q == AMT_W'(1)) state_d = RESP;
                end
                RESP: begin
                    res_valid = 1'b1;
                    res_data  = sh_q;
                    if (res_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed + random bench for shift_sequencer with a behavioural shifter
// attached and an arithmetic reference for the expected shift result.
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       reset_n, clear, cmd_valid, cmd_ready, cmd_asr;
    logic [7:0] cmd_data, res_data, sh_load_val, sh_q;
    logic [3:0] cmd_amt;
    logic       res_valid, res_ready, busy, sh_load_n, sh_shift, sh_asr, sh_reset_n;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    shift_sequencer #(.WIDTH(8), .AMT_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .cmd_amt(cmd_amt), .cmd_asr(cmd_asr),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy), .sh_load_val(sh_load_val), .sh_load_n(sh_load_n),
        .sh_shift(sh_shift), .sh_asr(sh_asr), .sh_reset_n(sh_reset_n),
        .sh_q(sh_q)
    );

    // external shifter: synchronous active-low reset, load has priority
    always @(posedge clk) begin
        if (!sh_reset_n)    sh_q <= 8'h00;
        else if (!sh_load_n) sh_q <= sh_load_val;
        else if (sh_shift)   sh_q <= sh_asr ? {sh_q[7], sh_q[7:1]} : {1'b0, sh_q[7:1]};
    end

    function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [3:0] a, input logic s);
        int sat;
        sat = (a > 8) ? 8 : int'(a);
        if (s) return 8'($signed(d) >>> sat);
        return 8'(d >> sat);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the controller idle; returns at a negedge, idle again.
    task automatic run_cmd(input logic [7:0] d, input logic [3:0] a, input logic s, input int hold);
        int sat, loads, shifts, found;
        logic asr_ok, lv_ok, busy_ok, stable;
        logic [7:0] held;
        sat = (a > 8) ? 8 : int'(a);
        loads = 0; shifts = 0; found = -1;
        asr_ok = 1'b1; lv_ok = 1'b1; busy_ok = 1'b1; stable = 1'b1;
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_data = d; cmd_amt = a; cmd_asr = s;
        @(negedge clk);
        // later changes on cmd_* must be ignored
        cmd_valid = 1'b0; cmd_data = 8'($urandom); cmd_amt = 4'($urandom); cmd_asr = 1'($urandom);
        for (int i = 0; i < 24 && found < 0; i++) begin
            if (res_valid) found = i;
            else begin
                if (!sh_load_n) begin
                    loads++;
                    if (sh_load_val !== d) lv_ok = 1'b0;
                end
                if (sh_shift) shifts++;
                if (sh_asr !== (sh_shift & s)) asr_ok = 1'b0;
                if (!busy || cmd_ready) busy_ok = 1'b0;
                @(negedge clk);
            end
        end
        check("latency", 32'(found), 32'(sat + 1));
        check("load_cycles", 32'(loads), 32'd1);
        check("shift_cycles", 32'(shifts), 32'(sat));
        check("load_val", 32'(lv_ok), 32'd1);
        check("asr_window", 32'(asr_ok), 32'd1);
        check("busy_during_op", 32'(busy_ok), 32'd1);
        check("res_data", 32'(res_data), 32'(ref_shift(d, a, s)));
        held = res_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!res_valid || res_data !== held || cmd_ready) stable = 1'b0;
        end
        if (hold > 0) check("backpressure_stable", 32'(stable), 32'd1);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("res_valid_after_hs", 32'(res_valid), 32'd0);
        check("cmd_ready_after_hs", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        reset_n = 1'b0; clear = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
        cmd_data = 8'h00; cmd_amt = 4'h0; cmd_asr = 1'b0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_sh_reset_n", 32'(sh_reset_n), 32'd0);
        check("rst_sh_load_n", 32'(sh_load_n), 32'd1);
        check("rst_sh_shift", 32'(sh_shift), 32'd0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        #1 check("sh_reset_n_idle", 32'(sh_reset_n), 32'd1);
        @(negedge clk);

        run_cmd(8'hB4, 4'd2, 1'b0, 0);
        run_cmd(8'hB4, 4'd3, 1'b1, 0);
        run_cmd(8'h81, 4'd0, 1'b0, 0);
        run_cmd(8'h81, 4'd15, 1'b1, 0);
        run_cmd(8'h81, 4'd8, 1'b0, 0);
        run_cmd(8'h5A, 4'd3, 1'b1, 5);

        // clear in the 2nd SHIFT cycle of an amt=5 op, with a command pending
        cmd_valid = 1'b1; cmd_data = 8'hC3; cmd_amt = 4'd5; cmd_asr = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        check("clr_in_shift", 32'(sh_shift), 32'd1);
        clear = 1'b1; cmd_valid = 1'b1; cmd_data = 8'h77; cmd_amt = 4'd1;
        #1;
        check("clr_sh_reset_n", 32'(sh_reset_n), 32'd0);
        check("clr_sh_shift", 32'(sh_shift), 32'd0);
        check("clr_cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("clr_busy_after", 32'(busy), 32'd0);
        check("clr_res_valid", 32'(res_valid), 32'd0);
        clear = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        check("clr_still_idle", 32'(busy), 32'd0);

        // async reset in the middle of SHIFT
        cmd_valid = 1'b1; cmd_data = 8'hF0; cmd_amt = 4'd6; cmd_asr = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_shift", 32'(sh_shift), 32'd0);
        check("arst_asr", 32'(sh_asr), 32'd0);
        check("arst_load_n", 32'(sh_load_n), 32'd1);
        check("arst_sh_reset_n", 32'(sh_reset_n), 32'd0);
        check("arst_res_valid", 32'(res_valid), 32'd0);
        check("arst_cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("arst_no_result", 32'(res_valid), 32'd0);
        run_cmd(8'h40, 4'd1, 1'b0, 0);

        for (int n = 0; n < 20; n++)
            run_cmd(8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom), int'($urandom_range(0, 3)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
